fsm_pattern_transmitter: RTL and testbench

//   Serial bit-pattern generator that drives the Din input of the serial sequence-detector FSMs.

---
 rtl/fsm_pattern_transmitter.sv | 106 ++++++++++
 tb/tb_fsm_pattern_transmitter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_transmitter.sv
// Serial bit-pattern generator: accepts a parallel word over a Load/Ready handshake
// and shifts it out one bit per clock on Dout, qualified by Dvalid, with Done on the last bit.
module fsm_pattern_transmitter #(
   parameter int WIDTH      = 8,
   parameter int GAP        = 1,
   parameter bit LSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] Data,
   output logic             Ready,
   output logic             Dout,
   output logic             Dvalid,
   output logic             Done
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]    bitcnt, bitcnt_n;
   logic [GW-1:0]    gapcnt, gapcnt_n;
   logic             dout_n, dvalid_n, done_n;

   // With GAP=0 the last-bit cycle also accepts the next frame, giving a seamless stream.
   assign Ready = (state == S_IDLE) ||
                  ((GAP == 0) && (state == S_SHIFT) && (bitcnt == '0));

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
      gapcnt_n = gapcnt;

      case (state)
         S_IDLE: begin
            if (Load) begin
               state_n  = S_SHIFT;
               shreg_n  = Data;
               bitcnt_n = BW'(WIDTH - 1);
            end
         end
         S_SHIFT: begin
            if (bitcnt != '0) begin
               shreg_n  = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
               bitcnt_n = bitcnt - BW'(1);
            end else if (GAP > 0) begin
               state_n  = S_GAP;
               gapcnt_n = GW'(GAP - 1);
            end else if (Load) begin
               shreg_n  = Data;
               bitcnt_n = BW'(WIDTH - 1);
            end else begin
               state_n  = S_IDLE;
            end
         end
         S_GAP: begin
            if (gapcnt == '0) state_n = S_IDLE;
            else              gapcnt_n = gapcnt - GW'(1);
         end
         default: begin
            state_n  = S_IDLE;
            bitcnt_n = '0;
            gapcnt_n = '0;
         end
      endcase

      // Outputs are computed from next state so Dout/Dvalid/Done come straight off flops.
      dvalid_n = (state_n == S_SHIFT);
      dout_n   = dvalid_n ? (LSB_FIRST ? shreg_n[0] : shreg_n[WIDTH-1]) : IDLE_LEVEL;
      done_n   = dvalid_n && (bitcnt_n == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state  <= S_IDLE;
         // NOTE: the shift register is cleared too; it costs little and keeps Dout free of X after reset.
         shreg  <= '0;
         bitcnt <= '0;
         gapcnt <= '0;
         Dout   <= IDLE_LEVEL;
         Dvalid <= 1'b0;
         Done   <= 1'b0;
      end else begin
         state  <= state_n;
         shreg  <= shreg_n;
         bitcnt <= bitcnt_n;
         gapcnt <= gapcnt_n;
         Dout   <= dout_n;
         Dvalid <= dvalid_n;
         Done   <= done_n;
      end
   end

endmodule

// File: tb/tb_fsm_pattern_transmitter.sv
// Bench for fsm_pattern_transmitter: three configurations (default, GAP=0, LSB-first/idle-high)
// with a per-instance scoreboard of expected serial bits checked on the falling edge.
module tb_fsm_pattern_transmitter;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Load   [3];
   logic [7:0] Data   [3];
   logic       Ready  [3];
   logic       Dout   [3];
   logic       Dvalid [3];
   logic       Done   [3];

   always #5 Clock = ~Clock;

   fsm_pattern_transmitter #(.WIDTH(8), .GAP(1), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_def (
      .Clock(Clock), .Reset(Reset), .Load(Load[0]), .Data(Data[0]),
      .Ready(Ready[0]), .Dout(Dout[0]), .Dvalid(Dvalid[0]), .Done(Done[0]));

   fsm_pattern_transmitter #(.WIDTH(8), .GAP(0), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b2b (
      .Clock(Clock), .Reset(Reset), .Load(Load[1]), .Data(Data[1]),
      .Ready(Ready[1]), .Dout(Dout[1]), .Dvalid(Dvalid[1]), .Done(Done[1]));

   fsm_pattern_transmitter #(.WIDTH(8), .GAP(1), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
      .Clock(Clock), .Reset(Reset), .Load(Load[2]), .Data(Data[2]),
      .Ready(Ready[2]), .Dout(Dout[2]), .Dvalid(Dvalid[2]), .Done(Done[2]));

   typedef struct packed {
      logic b;
      logic d;
   } exp_t;

   exp_t sb_q [3][$];
   int   passed = 0;
   int   total  = 0;
   bit   mon_en = 1'b0;

   function automatic logic idle_lvl(input int id);
      return (id == 2) ? 1'b1 : 1'b0;
   endfunction

   // Expected serial bits for a frame; a truncated frame never carries Done.
   task automatic push_frame(input int id, input logic [7:0] d, input bit lsb, input int nbits);
      exp_t e;
      for (int i = 0; i < nbits; i++) begin
         e.b = lsb ? d[i] : d[7-i];
         e.d = (i == 7);
         sb_q[id].push_back(e);
      end
   endtask

   always @(negedge Clock) begin
      exp_t e;
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (Dvalid[i] === 1'b1) begin
               total++;
               if (sb_q[i].size() == 0) begin
                  $display("FAIL unexpected_bit dut%0d: Dvalid=1 Dout=%b but no bit expected", i, Dout[i]);
               end else begin
                  passed++;
                  e = sb_q[i].pop_front();
                  total++;
                  if (Dout[i] !== e.b)
                     $display("FAIL sb_dout dut%0d: got %b expected %b", i, Dout[i], e.b);
                  else passed++;
                  total++;
                  if (Done[i] !== e.d)
                     $display("FAIL sb_done dut%0d: got %b expected %b", i, Done[i], e.d);
                  else passed++;
               end
            end else begin
               total++;
               if (Dout[i] !== idle_lvl(i) || Done[i] !== 1'b0 || Dvalid[i] !== 1'b0)
                  $display("FAIL idle_outputs dut%0d: Dvalid=%b Dout=%b Done=%b expected 0/%b/0",
                           i, Dvalid[i], Dout[i], Done[i], idle_lvl(i));
               else passed++;
            end
         end
      end
   end

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Load[i] = 1'b1;
         Data[i] = 8'hFF;
      end
      tick;
      mon_en = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (Ready[i] !== 1'b1 || Dvalid[i] !== 1'b0 || Dout[i] !== idle_lvl(i))
            $display("FAIL reset_state dut%0d: Ready=%b Dvalid=%b Dout=%b expected 1/0/%b",
                     i, Ready[i], Dvalid[i], Dout[i], idle_lvl(i));
         else passed++;
      end
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) Load[i] = 1'b0;
      tick;
      tick;
   endtask

   // Single B4 frame on the default instance, optionally with Loads injected while busy.
   task automatic test_frame(input bit inject);
      Load[0] = 1'b1;
      Data[0] = 8'hB4;
      push_frame(0, 8'hB4, 1'b0, 8);
      tick;
      Load[0] = 1'b0;
      Data[0] = 8'h5A;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (inject && (cyc == 3 || cyc == 9)) begin
            Load[0] = 1'b1;
            Data[0] = 8'h00;
         end else begin
            Load[0] = 1'b0;
         end
         @(negedge Clock);
         total++;
         if (Dvalid[0] !== (cyc <= 8))
            $display("FAIL frame_dvalid cyc k+%0d: got %b expected %b", cyc, Dvalid[0], cyc <= 8);
         else passed++;
         total++;
         if (Ready[0] !== (cyc == 10))
            $display("FAIL frame_ready cyc k+%0d: got %b expected %b", cyc, Ready[0], cyc == 10);
         else passed++;
         tick;
      end
      Load[0] = 1'b0;
   endtask

   task automatic test_back_to_back;
      Load[1] = 1'b1;
      Data[1] = 8'hF0;
      push_frame(1, 8'hF0, 1'b0, 8);
      push_frame(1, 8'h0F, 1'b0, 8);
      tick;
      Data[1] = 8'h0F;
      for (int cyc = 1; cyc <= 17; cyc++) begin
         @(negedge Clock);
         total++;
         if (Dvalid[1] !== (cyc <= 16))
            $display("FAIL b2b_dvalid cyc k+%0d: got %b expected %b", cyc, Dvalid[1], cyc <= 16);
         else passed++;
         total++;
         if (Ready[1] !== (cyc == 8 || cyc >= 16))
            $display("FAIL b2b_ready cyc k+%0d: got %b expected %b", cyc, Ready[1], cyc == 8 || cyc >= 16);
         else passed++;
         tick;
         if (cyc == 8) Load[1] = 1'b0;
      end
   endtask

   task automatic test_reset_mid_frame;
      Load[0] = 1'b1;
      Data[0] = 8'hB4;
      push_frame(0, 8'hB4, 1'b0, 4);
      tick;
      Load[0] = 1'b0;
      for (int cyc = 1; cyc <= 3; cyc++) tick;
      Reset = 1'b0;
      tick;
      Reset = 1'b1;
      @(negedge Clock);
      total++;
      if (Dvalid[0] !== 1'b0 || Dout[0] !== 1'b0 || Ready[0] !== 1'b1 || Done[0] !== 1'b0)
         $display("FAIL mid_reset: Dvalid=%b Dout=%b Ready=%b Done=%b expected 0/0/1/0",
                  Dvalid[0], Dout[0], Ready[0], Done[0]);
      else passed++;
      tick;
      test_frame(1'b0);
   endtask

   task automatic test_lsb_idle_high;
      Load[2] = 1'b1;
      Data[2] = 8'h01;
      push_frame(2, 8'h01, 1'b1, 8);
      tick;
      Load[2] = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge Clock);
         total++;
         if (Dvalid[2] !== (cyc <= 8))
            $display("FAIL lsb_dvalid cyc k+%0d: got %b expected %b", cyc, Dvalid[2], cyc <= 8);
         else passed++;
         if (cyc >= 9) begin
            total++;
            if (Dout[2] !== 1'b1)
               $display("FAIL lsb_idle_level cyc k+%0d: got %b expected 1", cyc, Dout[2]);
            else passed++;
         end
         tick;
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         Load[i] = 1'b0;
         Data[i] = 8'h00;
      end
      Reset = 1'b1;
      #1;
      test_reset;
      test_frame(1'b0);
      test_frame(1'b1);
      test_back_to_back;
      test_reset_mid_frame;
      test_lsb_idle_high;
      for (int i = 0; i < 4; i++) tick;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (sb_q[i].size() != 0)
            $display("FAIL sb_drain dut%0d: %0d bits never produced, expected 0", i, sb_q[i].size());
         else passed++;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
